io_event_latch: RTL

Parametrised event-latch and NMI controller for the peripheral I/O space. It generalises the single keyboard latch and NMI mask port to N event sources, each with a synchroniser, glitch filter, selectable edge polarity, mask and sticky latch. The CPU reads and clears pending events through four byte registers at `BASE_ADDRESS`. The block drives `NMI` and a priority-encoded event index, and returns read data through the same `DATA_OUT` / `peripherals_data_out` mux convention as the other peripherals.

---
 rtl/io_event_pkg.sv | 23 ++
 rtl/io_event_channel.sv | 50 +++++
 rtl/io_event_latch.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/io_event_pkg.sv
// Shared register map, CONTROL bit positions and the pending-event priority encoder
// for the I/O event latch.
package io_event_pkg;

    localparam logic [1:0] REG_ENABLE   = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_POLARITY = 2'd2;
    localparam logic [1:0] REG_CONTROL  = 2'd3;

    localparam int CTRL_NMI_ENABLE_BIT    = 0;
    localparam int CTRL_CLEAR_ON_READ_BIT = 1;

    // Lowest set bit wins; an all-zero vector maps to index 0.
    function automatic logic [2:0] lowest_set_index(input logic [7:0] vec);
        lowest_set_index = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                lowest_set_index = 3'(i);
            end
        end
    endfunction

endpackage

// File: rtl/io_event_channel.sv
// One event source: two-flop synchroniser, glitch filter, accepted level and a
// one-clock pulse when an accepted transition matches the selected polarity.
module io_event_channel #(
    parameter logic [15:0] FILTER_CYCLES = 16'd4
) (
    input  logic clock,
    input  logic reset,
    input  logic event_in,
    input  logic polarity,
    output logic event_level,
    output logic edge_pulse
);

    localparam logic [15:0] LAST_COUNT = FILTER_CYCLES - 16'd1;

    logic        sync1_r;
    logic        sync2_r;
    logic [15:0] count_r;
    logic        level_r;
    logic        pulse_r;

    // Synchronise, count consecutive disagreeing clocks, accept the new level once stable.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            count_r <= 16'd0;
            level_r <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            sync1_r <= event_in;
            sync2_r <= sync1_r;
            pulse_r <= 1'b0;
            if (sync2_r == level_r) begin
                count_r <= 16'd0;
            end else if (count_r >= LAST_COUNT) begin
                // polarity 0 wants a new level of 1, polarity 1 wants a new level of 0
                level_r <= sync2_r;
                count_r <= 16'd0;
                pulse_r <= (sync2_r != polarity);
            end else begin
                count_r <= count_r + 16'd1;
            end
        end
    end

    assign event_level = level_r;
    assign edge_pulse  = pulse_r;

endmodule

// File: rtl/io_event_latch.sv
// N-source event latch and NMI controller with ENABLE/STATUS/POLARITY/CONTROL
// byte registers in the peripheral I/O space.
module io_event_latch
    import io_event_pkg::*;
#(
    parameter int          NUM_EVENTS    = 8,
    parameter logic [15:0] FILTER_CYCLES = 16'd4,
    parameter logic [9:0]  BASE_ADDRESS  = 10'h0A0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [19:0]           ADDRESS,
    input  logic [7:0]            DATA_IN,
    output logic [7:0]            DATA_OUT,
    input  logic                  X_IO_OR_M,
    input  logic                  IOR_N,
    input  logic                  IOW_N,
    output logic                  peripherals_data_out,
    input  logic [NUM_EVENTS-1:0] event_in,
    output logic [NUM_EVENTS-1:0] event_level,
    output logic [2:0]            event_id,
    output logic                  NMI
);

    logic                  decode_s;
    logic                  cs_n_s;
    logic                  wr_strobe_n_s;
    logic                  rd_strobe_n_s;
    logic                  wr_commit_s;
    logic                  rd_release_s;
    logic                  read_sel_s;
    logic [NUM_EVENTS-1:0] edge_s;
    logic [NUM_EVENTS-1:0] active_s;
    logic [NUM_EVENTS-1:0] wr_clear_s;
    logic [NUM_EVENTS-1:0] rd_clear_s;
    logic [7:0]            control_s;
    logic [7:0]            read_data_s;
    logic                  unused_address_s;

    logic                  wr_strobe_n_r;
    logic                  rd_strobe_n_r;
    logic [NUM_EVENTS-1:0] enable_r;
    logic [NUM_EVENTS-1:0] polarity_r;
    logic [NUM_EVENTS-1:0] pending_r;
    logic [NUM_EVENTS-1:0] snapshot_r;
    logic                  snap_status_r;
    logic                  nmi_enable_r;
    logic                  clear_on_read_r;
    logic                  nmi_r;
    logic [2:0]            event_id_r;

    assign unused_address_s = &{1'b0, ADDRESS[19:10]};

    // Address decode, strobe qualification and trailing-edge detection.
    always_comb begin
        decode_s      = ({ADDRESS[9:2], 2'b00} == BASE_ADDRESS);
        cs_n_s        = ~(X_IO_OR_M & decode_s);
        wr_strobe_n_s = cs_n_s | IOW_N;
        rd_strobe_n_s = cs_n_s | IOR_N;
        wr_commit_s   = ~wr_strobe_n_r & wr_strobe_n_s;
        rd_release_s  = ~rd_strobe_n_r & rd_strobe_n_s;
        read_sel_s    = ~IOR_N & ~cs_n_s;
        active_s      = pending_r & enable_r;
        wr_clear_s    = (wr_commit_s && (ADDRESS[1:0] == REG_STATUS))
                        ? DATA_IN[NUM_EVENTS-1:0] : '0;
        rd_clear_s    = (rd_release_s && snap_status_r && clear_on_read_r) ? snapshot_r : '0;
    end

    for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_channel
        io_event_channel #(
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_channel (
            .clock       (clock),
            .reset       (reset),
            .event_in    (event_in[i]),
            .polarity    (polarity_r[i]),
            .event_level (event_level[i]),
            .edge_pulse  (edge_s[i])
        );
    end

    // Bus-side state: strobe history, read snapshot and the R/W registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_strobe_n_r   <= 1'b1;
            rd_strobe_n_r   <= 1'b1;
            snapshot_r      <= '0;
            snap_status_r   <= 1'b0;
            enable_r        <= '0;
            polarity_r      <= '0;
            nmi_enable_r    <= 1'b0;
            clear_on_read_r <= 1'b0;
        end else begin
            wr_strobe_n_r <= wr_strobe_n_s;
            rd_strobe_n_r <= rd_strobe_n_s;
            // The last value presented while the read strobe was low is what gets cleared.
            if (~rd_strobe_n_s) begin
                snapshot_r    <= pending_r;
                snap_status_r <= (ADDRESS[1:0] == REG_STATUS);
            end
            if (wr_commit_s) begin
                case (ADDRESS[1:0])
                    REG_ENABLE:   enable_r   <= DATA_IN[NUM_EVENTS-1:0];
                    REG_POLARITY: polarity_r <= DATA_IN[NUM_EVENTS-1:0];
                    REG_CONTROL: begin
                        nmi_enable_r    <= DATA_IN[CTRL_NMI_ENABLE_BIT];
                        clear_on_read_r <= DATA_IN[CTRL_CLEAR_ON_READ_BIT];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sticky pending latch (a new edge beats any clear) and the registered interrupt outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_r  <= '0;
            nmi_r      <= 1'b0;
            event_id_r <= 3'd0;
        end else begin
            pending_r  <= (pending_r & ~(wr_clear_s | rd_clear_s)) | edge_s;
            nmi_r      <= nmi_enable_r & (|active_s);
            event_id_r <= lowest_set_index(8'(active_s));
        end
    end

    // Combinational read mux; 8'hFF when this block is not being read.
    always_comb begin
        control_s                         = 8'h00;
        control_s[CTRL_NMI_ENABLE_BIT]    = nmi_enable_r;
        control_s[CTRL_CLEAR_ON_READ_BIT] = clear_on_read_r;
        case (ADDRESS[1:0])
            REG_ENABLE:   read_data_s = 8'(enable_r);
            REG_STATUS:   read_data_s = 8'(pending_r);
            REG_POLARITY: read_data_s = 8'(polarity_r);
            REG_CONTROL:  read_data_s = control_s;
            default:      read_data_s = 8'hFF;
        endcase
    end

    assign DATA_OUT             = read_sel_s ? read_data_s : 8'hFF;
    assign peripherals_data_out = read_sel_s;
    assign NMI                  = nmi_r;
    assign event_id             = event_id_r;

endmodule
